// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single-port RAM to either the instruction cache or the
// data cache, one word at a time. The data side has priority, but a saturating
// starvation counter forces an instruction grant after STARVE_LIMIT consecutive
// data grants taken while an instruction fetch was pending.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    // instruction cache side
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // data cache side
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // RAM side
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [2:0] LIMIT      = 3'(STARVE_LIMIT);
    localparam logic [2:0] CNT_MAX    = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISERVE = 2'd1,
        DSERVE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] starve_cnt_q, starve_cnt_d;
    logic       dreq;

    // A write counts as a data request even with dREN low.
    assign dreq = dREN | dWEN;

    // State and starvation counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            starve_cnt_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Grant selection, RAM request muxing and completion signalling.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        iwait        = 1'b1;
        dwait        = 1'b1;
        iload        = 32'd0;
        dload        = 32'd0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = 32'd0;
        ramstore     = 32'd0;

        unique case (state_q)
            IDLE: begin
                // No pending fetch means nothing is being starved.
                if (!iREN) begin
                    starve_cnt_d = 3'd0;
                end
                if (dreq && iREN) begin
                    state_d = (starve_cnt_q >= LIMIT) ? ISERVE : DSERVE;
                end else if (dreq) begin
                    state_d = DSERVE;
                end else if (iREN) begin
                    state_d = ISERVE;
                end
            end

            DSERVE: begin
                dload = ramload;
                if (!dreq) begin
                    // Requester withdrew: abandon the word, RAM idle this cycle.
                    state_d = IDLE;
                end else begin
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ramstate == RAM_ACCESS) begin
                        dwait   = 1'b0;
                        state_d = IDLE;
                        if (iREN && starve_cnt_q != CNT_MAX) begin
                            starve_cnt_d = starve_cnt_q + 3'd1;
                        end
                    end
                end
            end

            ISERVE: begin
                iload = ramload;
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == RAM_ACCESS) begin
                        iwait        = 1'b0;
                        starve_cnt_d = 3'd0;
                        state_d      = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: one task per scenario, inline checks.
module tb_mem_arbiter;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic go_idle();
        iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
        tick(); tick();
    endtask

    task automatic test_reset();
        RST = 1; iREN = 0; dREN = 1; dWEN = 0;
        iaddr = 32'h0; daddr = 32'h44; dstore = 32'h0;
        ramload = 32'h5555_AAAA; ramstate = ACCESS;
        tick(); tick();
        #1;
        tests++; if (dwait !== 1'b1) begin fails++; $display("FAIL reset_dwait got %b want 1", dwait); end
        tests++; if (iwait !== 1'b1) begin fails++; $display("FAIL reset_iwait got %b want 1", iwait); end
        tests++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin fails++; $display("FAIL reset_ramen got %b%b want 00", ramREN, ramWEN); end
        tests++; if (ramaddr !== 32'h0 || dload !== 32'h0) begin fails++; $display("FAIL reset_outs addr %h dload %h want 0", ramaddr, dload); end
        RST = 0;
        #1;
        tests++; if (ramREN !== 1'b0) begin fails++; $display("FAIL release_idle_ramREN got %b want 0", ramREN); end
        tick();
        tests++; if (ramREN !== 1'b1 || ramaddr !== 32'h44) begin fails++; $display("FAIL release_grant ramREN %b addr %h want 1 00000044", ramREN, ramaddr); end
        go_idle();
    endtask

    task automatic test_data_read();
        dREN = 1; daddr = 32'h40; ramstate = BUSY; ramload = 32'hDEAD_0000;
        #1;
        tests++; if (ramREN !== 1'b0) begin fails++; $display("FAIL rd_latency ramREN %b want 0", ramREN); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40 || dwait !== 1'b1) begin
                fails++; $display("FAIL rd_busy%0d REN %b WEN %b addr %h dwait %b want 1 0 00000040 1", i, ramREN, ramWEN, ramaddr, dwait);
            end
        end
        tick();
        ramstate = ACCESS; ramload = 32'h1234_5678;
        #1;
        tests++; if (dwait !== 1'b0 || dload !== 32'h1234_5678) begin fails++; $display("FAIL rd_done dwait %b dload %h want 0 12345678", dwait, dload); end
        tests++; if (iwait !== 1'b1) begin fails++; $display("FAIL rd_iwait got %b want 1", iwait); end
        tick();
        #1;
        tests++; if (dwait !== 1'b1 || ramREN !== 1'b0 || dload !== 32'h0) begin fails++; $display("FAIL rd_after dwait %b REN %b dload %h want 1 0 0", dwait, ramREN, dload); end
        go_idle();
    endtask

    task automatic test_starvation();
        int  ncomp;
        logic exp_i;
        ncomp = 0;
        iREN = 1; dREN = 1; dWEN = 0; iaddr = 32'h1000; daddr = 32'h2000;
        ramstate = ACCESS; ramload = 32'h0BAD_F00D;
        for (int cyc = 0; cyc < 40 && ncomp < 10; cyc++) begin
            tick();
            #1;
            tests++;
            if (ramREN === 1'b1 && ramWEN === 1'b1) begin fails++; $display("FAIL starve_both_en cycle %0d", cyc); end
            if (dwait === 1'b0 || iwait === 1'b0) begin
                exp_i = (ncomp % 5 == 4);
                tests++;
                if ({iwait, dwait} !== (exp_i ? 2'b01 : 2'b10) ||
                    ramaddr !== (exp_i ? 32'h1000 : 32'h2000)) begin
                    fails++;
                    $display("FAIL starve_order completion %0d iwait %b dwait %b addr %h want I=%b", ncomp, iwait, dwait, ramaddr, exp_i);
                end
                ncomp++;
            end
        end
        tests++; if (ncomp != 10) begin fails++; $display("FAIL starve_count got %0d completions want 10", ncomp); end
        tick();
        go_idle();
    endtask

    task automatic test_write();
        dWEN = 1; dREN = 1; daddr = 32'h3100; dstore = 32'hBAD1_BAD1; ramstate = FREE;
        tick();
        tests++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hBAD1_BAD1 || ramaddr !== 32'h3100) begin
            fails++; $display("FAIL wr_drive WEN %b REN %b store %h addr %h want 1 0 bad1bad1 00003100", ramWEN, ramREN, ramstore, ramaddr);
        end
        tests++; if (dwait !== 1'b1) begin fails++; $display("FAIL wr_wait got %b want 1", dwait); end
        ramstate = ACCESS;
        #1;
        tests++; if (dwait !== 1'b0) begin fails++; $display("FAIL wr_done dwait %b want 0", dwait); end
        tick();
        dWEN = 0; dREN = 0;
        #1;
        tests++; if (ramWEN !== 1'b0 || dwait !== 1'b1) begin fails++; $display("FAIL wr_after WEN %b dwait %b want 0 1", ramWEN, dwait); end
        go_idle();
    endtask

    task automatic test_error_retry();
        iREN = 1; iaddr = 32'h200; ramstate = ERROR; ramload = 32'h1111_1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h200 || ramstore !== 32'h0 || iwait !== 1'b1) begin
                fails++; $display("FAIL err_hold%0d REN %b WEN %b addr %h store %h iwait %b want 1 0 00000200 0 1", i, ramREN, ramWEN, ramaddr, ramstore, iwait);
            end
        end
        tick();
        ramstate = ACCESS; ramload = 32'hCAFE_F00D;
        #1;
        tests++; if (iwait !== 1'b0 || iload !== 32'hCAFE_F00D || dwait !== 1'b1) begin fails++; $display("FAIL err_done iwait %b iload %h dwait %b want 0 cafef00d 1", iwait, iload, dwait); end
        tick();
        tests++; if (iwait !== 1'b1 || ramREN !== 1'b0) begin fails++; $display("FAIL err_single_pulse iwait %b REN %b want 1 0", iwait, ramREN); end
        go_idle();
    endtask

    task automatic test_drop();
        dREN = 1; iREN = 1; daddr = 32'h80; iaddr = 32'h600; ramstate = BUSY;
        tick();
        tests++; if (ramREN !== 1'b1 || ramaddr !== 32'h80) begin fails++; $display("FAIL drop_dgrant REN %b addr %h want 1 00000080", ramREN, ramaddr); end
        tick();
        dREN = 0;
        #1;
        tests++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 1'b1) begin fails++; $display("FAIL drop_same_cycle REN %b WEN %b dwait %b want 0 0 1", ramREN, ramWEN, dwait); end
        tick();
        tests++; if (ramREN !== 1'b0 || dwait !== 1'b1 || iwait !== 1'b1) begin fails++; $display("FAIL drop_idle REN %b dwait %b iwait %b want 0 1 1", ramREN, dwait, iwait); end
        tick();
        tests++; if (ramREN !== 1'b1 || ramaddr !== 32'h600) begin fails++; $display("FAIL drop_igrant REN %b addr %h want 1 00000600", ramREN, ramaddr); end
        ramstate = ACCESS;
        #1;
        tests++; if (iwait !== 1'b0 || dwait !== 1'b1) begin fails++; $display("FAIL drop_idone iwait %b dwait %b want 0 1", iwait, dwait); end
        tick();
        go_idle();
    endtask

    task automatic test_reset_midserve();
        dREN = 1; daddr = 32'h90; ramstate = BUSY; ramload = 32'h7777_7777;
        tick();
        tests++; if (ramREN !== 1'b1) begin fails++; $display("FAIL midrst_grant REN %b want 1", ramREN); end
        RST = 1;
        #1;
        tests++; if (ramREN !== 1'b0 || ramaddr !== 32'h0 || dwait !== 1'b1 || dload !== 32'h0) begin fails++; $display("FAIL midrst_outs REN %b addr %h dwait %b dload %h want 0 0 1 0", ramREN, ramaddr, dwait, dload); end
        tick();
        RST = 0;
        go_idle();
    endtask

    initial begin
        test_reset();
        test_data_read();
        test_starvation();
        test_write();
        test_error_retry();
        test_drop();
        test_reset_midserve();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
